// File: rtl/stack_seq_pkg.sv
// Shared types and sizing helpers for the stack sequencer (frame-reversal engine).
// Pure declarations: no logic, no latency, no backpressure.
package stack_seq_pkg;

    typedef enum logic [2:0] {
        FILL,
        PUSH,
        POP,
        WAIT,
        DRAIN
    } stack_seq_state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 100;

    // Width of a counter that must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Bundles the producer stream, the consumer stream and the LIFO stack port of the sequencer.
// The frame_len count is present only when STACK_SEQ_CNT_EN is defined.
interface stack_sequencer_if
    import stack_seq_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              stack_full;
    logic              stack_empty;

    logic              frame_trunc;
`ifdef STACK_SEQ_CNT_EN
    logic [cnt_w(DEPTH)-1:0] frame_len;
`endif

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output push, pop, write_data,
        input  read_data, stack_full, stack_empty,
        output frame_trunc
`ifdef STACK_SEQ_CNT_EN
        , output frame_len
`endif
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  push, pop, write_data,
        output read_data, stack_full, stack_empty,
        input  frame_trunc
`ifdef STACK_SEQ_CNT_EN
        , input frame_len
`endif
    );

endinterface

// File: rtl/stack_seq_out_reg.sv
// Output holding register: loads a popped word in one cycle, holds it stable while out_ready is low,
// and drops out_valid on the handshake.
module stack_seq_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Pushes an input frame into an external LIFO, then pops it out reversed; 3 cycles last push to first word.
// One word per 2 cycles in, one per 3 cycles out; input stalls while draining. Option: STACK_SEQ_CNT_EN adds frame_len.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    stack_sequencer_if.master bus
);

    stack_seq_state_t  state;
    logic              last_q;
    logic              push_q;
    logic              pop_q;
    logic              trunc_q;
    logic [DATA_W-1:0] wdata_q;

    logic              out_valid_w;
    logic [DATA_W-1:0] out_data_w;
    logic              out_last_w;

    logic              accept;
    logic              out_hs;
    logic              load;

    assign bus.in_ready = (state == FILL) && !bus.stack_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_hs       = out_valid_w && bus.out_ready;
    // The stack's read_data and empty flag are current during WAIT, one cycle after pop.
    assign load         = (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            last_q  <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            trunc_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            trunc_q <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        wdata_q <= bus.in_data;
                        last_q  <= bus.in_last;
                        push_q  <= 1'b1;
                        state   <= PUSH;
                    end else if (bus.stack_full && !bus.stack_empty) begin
                        // Stack filled before in_last: reverse what we have, rest becomes a new frame.
                        trunc_q <= 1'b1;
                        pop_q   <= 1'b1;
                        state   <= POP;
                    end
                end
                PUSH: begin
                    if (last_q) begin
                        pop_q <= 1'b1;
                        state <= POP;
                    end else begin
                        state <= FILL;
                    end
                end
                POP: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (out_last_w) begin
                            state <= FILL;
                        end else begin
                            pop_q <= 1'b1;
                            state <= POP;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    stack_seq_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (bus.read_data),
        .load_last (bus.stack_empty),
        .out_ready (bus.out_ready),
        .out_valid (out_valid_w),
        .out_data  (out_data_w),
        .out_last  (out_last_w)
    );

    assign bus.push        = push_q;
    assign bus.pop         = pop_q;
    assign bus.write_data  = wdata_q;
    assign bus.frame_trunc = trunc_q;
    assign bus.out_valid   = out_valid_w;
    assign bus.out_data    = out_data_w;
    assign bus.out_last    = out_last_w;

`ifdef STACK_SEQ_CNT_EN
    localparam int CNT_W = cnt_w(DEPTH);

    logic [CNT_W-1:0] len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
        end else if (push_q) begin
            len_q <= len_q + CNT_W'(1);
        end else if (pop_q) begin
            len_q <= len_q - CNT_W'(1);
        end
    end

    assign bus.frame_len = len_q;
`endif

endmodule
